// File: rtl/tilemap_compositor_pkg.sv
// Shared definitions for the tilemap compositor: map entry layout,
// register window decoding and the byte-enable merge helper.
package tilemap_compositor_pkg;

    localparam int BUS_W      = 32;
    localparam int ENTRY_W    = 16;
    localparam int CODE_LSB   = 0;
    localparam int COLOUR_LSB = 8;

    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_SCROLL = 2'd1,
        REG_ENABLE = 2'd2,
        REG_BG     = 2'd3
    } reg_kind_e;

    // Layer l owns offsets 2l (scroll) and 2l+1 (enable); bg sits right after them.
    function automatic reg_kind_e decode_reg(input int unsigned off, input int unsigned layers);
        reg_kind_e kind;
        if (off < 32'd2 * layers) begin
            kind = off[0] ? REG_ENABLE : REG_SCROLL;
        end else if (off == 32'd2 * layers) begin
            kind = REG_BG;
        end else begin
            kind = REG_NONE;
        end
        return kind;
    endfunction

    function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old_word,
                                                     input logic [BUS_W-1:0] wdata,
                                                     input logic [3:0]       we);
        logic [BUS_W-1:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = we[b] ? wdata[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/tilemap_layer_pipe.sv
// One tile layer: scroll arithmetic, its map RAM (bus port + render port)
// and pipeline stages S0-S2 up to the per-layer opaque bit and colour.
module tilemap_layer_pipe
    import tilemap_compositor_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROWS     = 16,
    parameter int TILE_W   = 8,
    parameter int TILE_H   = 8,
    parameter int SCREEN_W = 128,
    parameter int SCREEN_H = 64,
    parameter int PIXEL_W  = 8,
    localparam int XW   = $clog2(SCREEN_W),
    localparam int YW   = $clog2(SCREEN_H),
    localparam int MXW  = $clog2(COLS * TILE_W),
    localparam int MYW  = $clog2(ROWS * TILE_H),
    localparam int FXW  = $clog2(TILE_W),
    localparam int FYW  = $clog2(TILE_H),
    localparam int WIW  = $clog2(COLS * ROWS / 2),
    localparam int GA_W = 8 + FYW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               re,
    input  logic [XW-1:0]      x,
    input  logic [YW-1:0]      y,
    input  logic [MXW-1:0]     scroll_x,
    input  logic [MYW-1:0]     scroll_y,
    input  logic               enable,
    input  logic [3:0]         bus_we,
    input  logic [WIW-1:0]     bus_idx,
    input  logic [BUS_W-1:0]   bus_data,
    output logic [BUS_W-1:0]   bus_q,
    output logic [GA_W-1:0]    glyph_addr,
    input  logic [TILE_W-1:0]  glyph_q,
    output logic               pix_bit,
    output logic [PIXEL_W-1:0] pix_colour
);

    localparam int WORDS = COLS * ROWS / 2;

    logic [BUS_W-1:0]   mem [WORDS];
    logic [MXW-1:0]     sx_s;
    logic [MYW-1:0]     sy_s;
    logic [WIW-1:0]     ridx_s;
    logic [BUS_W-1:0]   rd_word_r;
    logic               half_r;
    logic [FXW-1:0]     fine_x1_r;
    logic [FYW-1:0]     fine_y1_r;
    logic               en1_r;
    logic [ENTRY_W-1:0] entry_s;
    logic [PIXEL_W-1:0] colour2_r;
    logic [FXW-1:0]     fine_x2_r;
    logic               en2_r;

    // S0: wrap into map space; two entries share a word, so drop the tile column LSB
    always_comb begin
        sx_s   = MXW'(x) + scroll_x;
        sy_s   = MYW'(y) + scroll_y;
        ridx_s = {sy_s[MYW-1:FYW], sx_s[MXW-1:FXW+1]};
    end

    // Bus write port with per-byte enables
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus_we[b]) begin
                mem[bus_idx][8*b +: 8] <= bus_data[8*b +: 8];
            end
        end
    end

    // Synchronous reads: bus port every cycle, render port on request (old data on collision)
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q     <= 32'd0;
            rd_word_r <= 32'd0;
            half_r    <= 1'b0;
            fine_x1_r <= {FXW{1'b0}};
            fine_y1_r <= {FYW{1'b0}};
            en1_r     <= 1'b0;
        end else begin
            bus_q <= mem[bus_idx];
            if (re) begin
                rd_word_r <= mem[ridx_s];
                half_r    <= sx_s[FXW];
                fine_x1_r <= sx_s[FXW-1:0];
                fine_y1_r <= sy_s[FYW-1:0];
                en1_r     <= enable;
            end
        end
    end

    // S1: pick the entry half and address the glyph ROM
    always_comb begin
        entry_s    = half_r ? rd_word_r[31:16] : rd_word_r[15:0];
        glyph_addr = {entry_s[CODE_LSB +: 8], fine_y1_r};
    end

    // S1 -> S2 register while the glyph ROM access is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            colour2_r <= {PIXEL_W{1'b0}};
            fine_x2_r <= {FXW{1'b0}};
            en2_r     <= 1'b0;
        end else begin
            colour2_r <= entry_s[COLOUR_LSB +: PIXEL_W];
            fine_x2_r <= fine_x1_r;
            en2_r     <= en1_r;
        end
    end

    // S2: opaque bit for this layer
    always_comb begin
        pix_bit    = glyph_q[fine_x2_r] & en2_r;
        pix_colour = colour2_r;
    end

endmodule

// File: rtl/tilemap_compositor.sv
// Multi-layer tilemap compositor: register file, frame-synchronous shadow
// registers, bus read mux and the final priority mux over LAYERS layer pipes.
module tilemap_compositor
    import tilemap_compositor_pkg::*;
#(
    parameter int LAYERS   = 2,
    parameter int COLS     = 32,
    parameter int ROWS     = 16,
    parameter int TILE_W   = 8,
    parameter int TILE_H   = 8,
    parameter int SCREEN_W = 128,
    parameter int SCREEN_H = 64,
    parameter int PIXEL_W  = 8,
    localparam int AW   = $clog2(LAYERS * COLS * ROWS / 2) + 1,
    localparam int PA_W = $clog2(SCREEN_W * SCREEN_H),
    localparam int GA_W = 8 + $clog2(TILE_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               bus_we,
    input  logic [AW-1:0]            bus_addr,
    input  logic [31:0]              bus_data,
    output logic [31:0]              bus_q,
    input  logic                     pixel_re,
    input  logic [PA_W-1:0]          pixel_addr,
    output logic                     pixel_valid,
    output logic [PIXEL_W-1:0]       pixel_data,
    output logic [LAYERS*GA_W-1:0]   glyph_addr,
    input  logic [LAYERS*TILE_W-1:0] glyph_q
);

    localparam int XW    = $clog2(SCREEN_W);
    localparam int MXW   = $clog2(COLS * TILE_W);
    localparam int MYW   = $clog2(ROWS * TILE_H);
    localparam int WIW   = $clog2(COLS * ROWS / 2);
    localparam int OFF_W = AW - 1;
    localparam int LBW   = AW - 1 - WIW;

    logic [BUS_W-1:0]   scroll_r [LAYERS];
    logic [LAYERS-1:0]  enable_r;
    logic [PIXEL_W-1:0] bg_r;
    logic [MXW-1:0]     sh_sx_r [LAYERS];
    logic [MYW-1:0]     sh_sy_r [LAYERS];
    logic [LAYERS-1:0]  sh_en_r;
    logic [PIXEL_W-1:0] sh_bg_r;
    logic [MXW-1:0]     eff_sx_s [LAYERS];
    logic [MYW-1:0]     eff_sy_s [LAYERS];
    logic [LAYERS-1:0]  eff_en_s;
    logic [PIXEL_W-1:0] eff_bg_s;
    logic               latch_s;
    logic [OFF_W-1:0]   off_s;
    reg_kind_e          kind_s;
    logic [BUS_W-1:0]   reg_rdata_s;
    logic [BUS_W-1:0]   reg_q_r;
    logic               sel_reg_r;
    logic [LBW-1:0]     lsel_r;
    logic [BUS_W-1:0]   map_sel_s;
    logic [BUS_W-1:0]   map_q_s [LAYERS];
    logic [3:0]         layer_we_s [LAYERS];
    logic [LAYERS-1:0]  bit_s;
    logic [PIXEL_W-1:0] colour_s [LAYERS];
    logic               v1_r;
    logic               v2_r;
    logic [PIXEL_W-1:0] bg1_r;
    logic [PIXEL_W-1:0] bg2_r;
    logic [PIXEL_W-1:0] mux_s;

    always_comb begin
        off_s  = bus_addr[OFF_W-1:0];
        kind_s = bus_addr[AW-1] ? decode_reg(32'(off_s), LAYERS) : REG_NONE;
        for (int l = 0; l < LAYERS; l++) begin
            layer_we_s[l] = (!bus_addr[AW-1] && (bus_addr[AW-2:WIW] == LBW'(l))) ? bus_we : 4'd0;
        end
    end

    // Live register file
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LAYERS; l++) begin
                scroll_r[l] <= 32'd0;
            end
            enable_r <= {LAYERS{1'b1}};
            bg_r     <= {PIXEL_W{1'b0}};
        end else if (|bus_we) begin
            case (kind_s)
                REG_SCROLL: begin
                    for (int l = 0; l < LAYERS; l++) begin
                        if (off_s[OFF_W-1:1] == (OFF_W-1)'(l)) begin
                            scroll_r[l] <= byte_merge(scroll_r[l], bus_data, bus_we);
                        end
                    end
                end
                REG_ENABLE: begin
                    for (int l = 0; l < LAYERS; l++) begin
                        if (bus_we[0] && (off_s[OFF_W-1:1] == (OFF_W-1)'(l))) begin
                            enable_r[l] <= bus_data[0];
                        end
                    end
                end
                REG_BG: begin
                    if (bus_we[0]) begin
                        bg_r <= bus_data[PIXEL_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        reg_rdata_s = 32'd0;
        case (kind_s)
            REG_SCROLL: begin
                for (int l = 0; l < LAYERS; l++) begin
                    reg_rdata_s = (off_s[OFF_W-1:1] == (OFF_W-1)'(l)) ? scroll_r[l] : reg_rdata_s;
                end
            end
            REG_ENABLE: begin
                for (int l = 0; l < LAYERS; l++) begin
                    reg_rdata_s = (off_s[OFF_W-1:1] == (OFF_W-1)'(l)) ? {31'd0, enable_r[l]} : reg_rdata_s;
                end
            end
            REG_BG:     reg_rdata_s = 32'(bg_r);
            default:    reg_rdata_s = 32'd0;
        endcase
    end

    // Capture bus read source so the map RAM output can be selected a cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg_r <= 1'b0;
            reg_q_r   <= 32'd0;
            lsel_r    <= {LBW{1'b0}};
        end else begin
            sel_reg_r <= bus_addr[AW-1];
            reg_q_r   <= reg_rdata_s;
            lsel_r    <= bus_addr[AW-2:WIW];
        end
    end

    always_comb begin
        map_sel_s = 32'd0;
        for (int l = 0; l < LAYERS; l++) begin
            map_sel_s = (lsel_r == LBW'(l)) ? map_q_s[l] : map_sel_s;
        end
        bus_q = sel_reg_r ? reg_q_r : map_sel_s;
    end

    // The frame-start pixel already renders with the values it latches
    always_comb begin
        latch_s = pixel_re && (pixel_addr == {PA_W{1'b0}});
        for (int l = 0; l < LAYERS; l++) begin
            eff_sx_s[l] = latch_s ? scroll_r[l][MXW-1:0]  : sh_sx_r[l];
            eff_sy_s[l] = latch_s ? scroll_r[l][16 +: MYW] : sh_sy_r[l];
        end
        eff_en_s = latch_s ? enable_r : sh_en_r;
        eff_bg_s = latch_s ? bg_r     : sh_bg_r;
    end

    // Shadow registers, updated only at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LAYERS; l++) begin
                sh_sx_r[l] <= {MXW{1'b0}};
                sh_sy_r[l] <= {MYW{1'b0}};
            end
            sh_en_r <= {LAYERS{1'b1}};
            sh_bg_r <= {PIXEL_W{1'b0}};
        end else if (latch_s) begin
            for (int l = 0; l < LAYERS; l++) begin
                sh_sx_r[l] <= eff_sx_s[l];
                sh_sy_r[l] <= eff_sy_s[l];
            end
            sh_en_r <= eff_en_s;
            sh_bg_r <= eff_bg_s;
        end
    end

    for (genvar g = 0; g < LAYERS; g++) begin : g_layer
        tilemap_layer_pipe #(
            .COLS     (COLS),
            .ROWS     (ROWS),
            .TILE_W   (TILE_W),
            .TILE_H   (TILE_H),
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H),
            .PIXEL_W  (PIXEL_W)
        ) u_layer (
            .clk        (clk),
            .rst        (rst),
            .re         (pixel_re),
            .x          (pixel_addr[XW-1:0]),
            .y          (pixel_addr[PA_W-1:XW]),
            .scroll_x   (eff_sx_s[g]),
            .scroll_y   (eff_sy_s[g]),
            .enable     (eff_en_s[g]),
            .bus_we     (layer_we_s[g]),
            .bus_idx    (bus_addr[WIW-1:0]),
            .bus_data   (bus_data),
            .bus_q      (map_q_s[g]),
            .glyph_addr (glyph_addr[g*GA_W +: GA_W]),
            .glyph_q    (glyph_q[g*TILE_W +: TILE_W]),
            .pix_bit    (bit_s[g]),
            .pix_colour (colour_s[g])
        );
    end

    // S3: highest-index opaque layer wins over the background
    always_comb begin
        mux_s = bg2_r;
        for (int l = 0; l < LAYERS; l++) begin
            mux_s = bit_s[l] ? colour_s[l] : mux_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            pixel_valid <= 1'b0;
            bg1_r       <= {PIXEL_W{1'b0}};
            bg2_r       <= {PIXEL_W{1'b0}};
            pixel_data  <= {PIXEL_W{1'b0}};
        end else begin
            v1_r        <= pixel_re;
            v2_r        <= v1_r;
            pixel_valid <= v2_r;
            if (pixel_re) begin
                bg1_r <= eff_bg_s;
            end
            bg2_r <= bg1_r;
            if (v2_r) begin
                pixel_data <= mux_s;
            end
        end
    end

endmodule

// File: tb/tb_tilemap_compositor.sv
// Directed bench for tilemap_compositor (default parameters) with a
// behavioural per-layer glyph ROM.
module tb_tilemap_compositor;

    logic        clk;
    logic        rst;
    logic [3:0]  bus_we;
    logic [9:0]  bus_addr;
    logic [31:0] bus_data;
    logic [31:0] bus_q;
    logic        pixel_re;
    logic [12:0] pixel_addr;
    logic        pixel_valid;
    logic [7:0]  pixel_data;
    logic [21:0] glyph_addr;
    logic [15:0] glyph_q;

    logic [7:0]  gmem0 [2048];
    logic [7:0]  gmem1 [2048];
    logic [21:0] last_ga;
    int          checks;
    int          failures;

    tilemap_compositor dut (
        .clk         (clk),
        .rst         (rst),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_data    (bus_data),
        .bus_q       (bus_q),
        .pixel_re    (pixel_re),
        .pixel_addr  (pixel_addr),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .glyph_addr  (glyph_addr),
        .glyph_q     (glyph_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle synchronous glyph ROMs
    always @(posedge clk) begin
        glyph_q[7:0]  <= gmem0[glyph_addr[10:0]];
        glyph_q[15:8] <= gmem1[glyph_addr[21:11]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] we);
        bus_addr = a;
        bus_data = d;
        bus_we   = we;
        step();
        bus_we   = 4'h0;
    endtask

    task automatic bus_read(input logic [9:0] a, input logic [31:0] exp, input string tag);
        bus_addr = a;
        bus_we   = 4'h0;
        step();
        chk(tag, bus_q, exp);
    endtask

    task automatic render(input logic [12:0] a, input logic [7:0] exp, input string tag);
        pixel_re   = 1'b1;
        pixel_addr = a;
        step();
        pixel_re = 1'b0;
        last_ga  = glyph_addr;
        chk({tag, "_c1"}, 32'(pixel_valid), 32'd0);
        step();
        chk({tag, "_c2"}, 32'(pixel_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(pixel_valid), 32'd1);
        chk({tag, "_data"}, 32'(pixel_data), 32'(exp));
        step();
        chk({tag, "_c4"}, 32'(pixel_valid), 32'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus_we     = 4'h0;
        bus_addr   = 10'd0;
        bus_data   = 32'd0;
        pixel_re   = 1'b0;
        pixel_addr = 13'd0;
        for (int i = 0; i < 2048; i++) begin
            gmem0[i] = 8'h00;
            gmem1[i] = 8'h00;
        end
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            bus_write(10'(i), 32'd0, 4'hF);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;

        chk("rst_valid", 32'(pixel_valid), 32'd0);
        chk("rst_data", 32'(pixel_data), 32'd0);
        chk("rst_busq", bus_q, 32'd0);
        chk("rst_glyph_addr", 32'(glyph_addr), 32'd0);
        bus_read(10'h200, 32'd0, "rst_scroll0");
        bus_read(10'h203, 32'd1, "rst_enable1");
        render(13'd0, 8'h00, "blank");

        // L0 tile(0,0) = colour 0x05 code 0x41, glyph row 0 = pixel 0 only
        bus_write(10'h000, 32'h0000_0541, 4'hF);
        gmem0[{8'h41, 3'd0}] = 8'h01;
        bus_write(10'h204, 32'h0000_0033, 4'hF);
        bus_read(10'h204, 32'h33, "bg_rd");
        bus_write(10'h205, 32'hFFFF_FFFF, 4'hF);
        bus_read(10'h205, 32'h0, "unused_rd");
        render(13'd0, 8'h05, "l0_px0");
        chk("l0_glyph_addr", 32'(last_ga), 32'h0000_0208);
        render(13'd1, 8'h33, "l0_px1");

        bus_write(10'h105, 32'h1122_3344, 4'hF);
        bus_write(10'h105, 32'hAABB_CCDD, 4'b0101);
        bus_read(10'h105, 32'h11BB_33DD, "byte_en");

        // L1 on top at (0,0), then L1 disabled
        bus_write(10'h100, 32'h0000_0A77, 4'hF);
        gmem1[{8'h77, 3'd0}] = 8'h01;
        render(13'd0, 8'h0A, "l1_top");
        chk("l1_glyph_addr", 32'(last_ga), 32'h001D_C208);
        bus_write(10'h203, 32'h0, 4'hF);
        bus_read(10'h203, 32'h0, "en_rd");
        render(13'd0, 8'h05, "l1_off");

        // scroll_x written mid-frame takes effect at the next frame start
        bus_write(10'h000, 32'h0642_0541, 4'hF);
        gmem0[{8'h42, 3'd0}] = 8'h01;
        bus_read(10'h000, 32'h0642_0541, "map_rd");
        bus_write(10'h200, 32'h0000_0008, 4'hF);
        render(13'd1, 8'h33, "scroll_held");
        render(13'd0, 8'h06, "scroll_new");
        render(13'd1, 8'h33, "scroll_new_x1");

        // wrap: scroll_x low bits 255, scroll_y low bits 120
        bus_write(10'h200, 32'hFFF8_FFFF, 4'hF);
        bus_read(10'h200, 32'hFFF8_FFFF, "scroll_rd");
        render(13'd0, 8'h33, "wrap_x0");
        render(13'h401, 8'h05, "wrap_x1y8");

        // back-to-back requests
        pixel_re = 1'b1;
        pixel_addr = 13'h401;
        step();
        pixel_addr = 13'h402;
        step();
        pixel_addr = 13'h401;
        step();
        pixel_re = 1'b0;
        chk("b2b_v0", 32'(pixel_valid), 32'd1);
        chk("b2b_d0", 32'(pixel_data), 32'h05);
        step();
        chk("b2b_v1", 32'(pixel_valid), 32'd1);
        chk("b2b_d1", 32'(pixel_data), 32'h33);
        step();
        chk("b2b_v2", 32'(pixel_valid), 32'd1);
        chk("b2b_d2", 32'(pixel_data), 32'h05);
        step();
        chk("b2b_end", 32'(pixel_valid), 32'd0);

        // reset mid-pipeline drops the in-flight pixel
        pixel_re = 1'b1;
        pixel_addr = 13'h401;
        step();
        pixel_re = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_v1", 32'(pixel_valid), 32'd0);
        step();
        chk("mid_rst_v2", 32'(pixel_valid), 32'd0);
        chk("mid_rst_data", 32'(pixel_data), 32'd0);
        step();
        chk("mid_rst_v3", 32'(pixel_valid), 32'd0);
        bus_read(10'h200, 32'd0, "mid_rst_scroll");
        bus_read(10'h203, 32'd1, "mid_rst_enable");
        bus_read(10'h000, 32'h0642_0541, "mid_rst_map_kept");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
